// File: rtl/counter_pkg.sv
// Shared encodings for the counter family: count direction and limit behaviour.
package counter_pkg;
    localparam logic MODE_SAT  = 1'b0;
    localparam logic MODE_WRAP = 1'b1;
    localparam logic DIR_DOWN  = 1'b0;
    localparam logic DIR_UP    = 1'b1;
endpackage

// File: rtl/updown_limit_counter_tick_prescaler.sv
// Enable prescaler: tick is combinational and asserts once every presc+1 enabled cycles.
// No backpressure; en low freezes the internal count.
module tick_prescaler #(
    parameter int PRESC_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               en,
    input  logic [PRESC_W-1:0] presc,
    output logic               tick
);
    logic [PRESC_W-1:0] r_pc;
    logic               w_wrap;

    // >= rather than == so that lowering presc below r_pc cannot strand the count
    assign w_wrap = (r_pc >= presc);
    assign tick   = en & w_wrap;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc <= '0;
        end else if (clr) begin
            r_pc <= '0;
        end else if (en) begin
            r_pc <= w_wrap ? '0 : r_pc + 1'b1;
        end
    end
endmodule

// File: rtl/updown_limit_counter.sv
// Up/down counter with programmable limits, saturate/wrap, load, clear and prescaled enable.
// out and tc update one cycle after a qualifying tick; flags are combinational; no backpressure.
module updown_limit_counter
    import counter_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int PRESC_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               load,
    input  logic [WIDTH-1:0]   load_val,
    input  logic               en,
    input  logic               dir,
    input  logic               mode,
    input  logic [WIDTH-1:0]   min_val,
    input  logic [WIDTH-1:0]   max_val,
    input  logic [PRESC_W-1:0] presc,
    output logic [WIDTH-1:0]   out,
    output logic               tc,
    output logic               at_max,
    output logic               at_min,
    output logic               cfg_err
);
    logic [WIDTH-1:0] r_out;
    logic             r_tc;
    logic             w_tick;
    logic             w_step;
    logic [WIDTH-1:0] w_inc;
    logic [WIDTH-1:0] w_dec;

    tick_prescaler #(
        .PRESC_W (PRESC_W)
    ) u_presc (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr | load),
        .en    (en),
        .presc (presc),
        .tick  (w_tick)
    );

    assign at_max  = (r_out >= max_val);
    assign at_min  = (r_out <= min_val);
    assign cfg_err = (min_val > max_val);
    assign w_step  = w_tick & ~cfg_err;
    // Only used when strictly inside the limits, so neither can roll over
    assign w_inc   = r_out + 1'b1;
    assign w_dec   = r_out - 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out <= '0;
            r_tc  <= 1'b0;
        end else if (clr) begin
            r_out <= min_val;
            r_tc  <= 1'b0;
        end else if (load) begin
            r_out <= load_val;
            r_tc  <= 1'b0;
        end else begin
            r_tc <= 1'b0;
            if (w_step) begin
                if (dir == DIR_UP) begin
                    if (r_out < max_val) begin
                        r_out <= w_inc;
                        r_tc  <= (w_inc == max_val);
                    end else if (mode == MODE_WRAP) begin
                        r_out <= min_val;
                        r_tc  <= 1'b1;
                    end else begin
                        r_out <= max_val;
                    end
                end else begin
                    if (r_out > min_val) begin
                        r_out <= w_dec;
                        r_tc  <= (w_dec == min_val);
                    end else if (mode == MODE_WRAP) begin
                        r_out <= max_val;
                        r_tc  <= 1'b1;
                    end else begin
                        r_out <= min_val;
                    end
                end
            end
        end
    end

    assign out = r_out;
    assign tc  = r_tc;
endmodule

// File: tb/tb_updown_limit_counter.sv
// Directed bench: expected out/tc pushed to a scoreboard queue per driven cycle, popped after the edge.
module tb_updown_limit_counter;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clr = 1'b0;
    logic       load = 1'b0;
    logic [7:0] load_val = '0;
    logic       en = 1'b0;
    logic       dir = 1'b1;
    logic       mode = 1'b0;
    logic [7:0] min_val = '0;
    logic [7:0] max_val = '0;
    logic [7:0] presc = '0;
    logic [7:0] out;
    logic       tc;
    logic       at_max;
    logic       at_min;
    logic       cfg_err;

    int n_vec = 0;
    int n_err = 0;
    logic [8:0] sb_q[$];

    updown_limit_counter #(.WIDTH(8), .PRESC_W(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .load     (load),
        .load_val (load_val),
        .en       (en),
        .dir      (dir),
        .mode     (mode),
        .min_val  (min_val),
        .max_val  (max_val),
        .presc    (presc),
        .out      (out),
        .tc       (tc),
        .at_max   (at_max),
        .at_min   (at_min),
        .cfg_err  (cfg_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Push expectation, clock once, then pop and compare away from the edge.
    task automatic cyc(input string tag, input logic [7:0] e_out, input logic e_tc);
        logic [8:0] e;
        sb_q.push_back({e_out, e_tc});
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        chk({tag, ".out"}, {24'd0, out}, {24'd0, e[8:1]});
        chk({tag, ".tc"}, {31'd0, tc}, {31'd0, e[0]});
    endtask

    initial begin
        logic [7:0] seq_out[6];
        logic       seq_tc[6];
        logic       en_seq[9];
        logic [7:0] p_out[9];

        // Reset state
        #12;
        chk("rst.out", {24'd0, out}, 32'd0);
        chk("rst.tc", {31'd0, tc}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 1: saturate up, 2..5
        min_val = 8'd2; max_val = 8'd5; mode = 1'b0; dir = 1'b1; presc = 8'd0; en = 1'b1;
        clr = 1'b1;
        cyc("sat.clr", 8'd2, 1'b0);
        clr = 1'b0;
        seq_out = '{8'd3, 8'd4, 8'd5, 8'd5, 8'd5, 8'd5};
        seq_tc  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 6; i++) cyc("sat", seq_out[i], seq_tc[i]);
        chk("sat.at_max", {31'd0, at_max}, 32'd1);
        chk("sat.at_min", {31'd0, at_min}, 32'd0);

        // 2: wrap up
        mode = 1'b1;
        clr = 1'b1;
        cyc("wrap.clr", 8'd2, 1'b0);
        clr = 1'b0;
        seq_out = '{8'd3, 8'd4, 8'd5, 8'd2, 8'd3, 8'd4};
        seq_tc  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 6; i++) cyc("wrap", seq_out[i], seq_tc[i]);

        // 3: wrap down across full range
        dir = 1'b0; min_val = 8'd0; max_val = 8'd255; load_val = 8'd1; load = 1'b1;
        cyc("down.load", 8'd1, 1'b0);
        load = 1'b0;
        cyc("down", 8'd0, 1'b1);
        chk("down.at_min", {31'd0, at_min}, 32'd1);
        cyc("down", 8'd255, 1'b1);
        chk("down.at_max", {31'd0, at_max}, 32'd1);
        cyc("down", 8'd254, 1'b0);

        // 4: prescaler, divide by 4 with an idle cycle
        dir = 1'b1; mode = 1'b0; presc = 8'd3; clr = 1'b1;
        cyc("presc.clr", 8'd0, 1'b0);
        clr = 1'b0;
        en_seq = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        p_out  = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd1, 8'd1, 8'd1, 8'd2};
        for (int i = 0; i < 9; i++) begin
            en = en_seq[i];
            cyc("presc", p_out[i], 1'b0);
        end

        // 5: load above max clamps; inverted limits freeze the count
        en = 1'b1; presc = 8'd0; max_val = 8'd100; load_val = 8'd200; load = 1'b1;
        cyc("clamp.load", 8'd200, 1'b0);
        chk("clamp.at_max", {31'd0, at_max}, 32'd1);
        load = 1'b0;
        cyc("clamp", 8'd100, 1'b0);
        min_val = 8'd150;
        #1;
        chk("cfg_err", {31'd0, cfg_err}, 32'd1);
        for (int i = 0; i < 5; i++) cyc("cfg_hold", 8'd100, 1'b0);

        // 6: async reset mid-count, then clr+load together
        min_val = 8'd0; max_val = 8'd255; clr = 1'b1;
        cyc("rst6.clr", 8'd0, 1'b0);
        clr = 1'b0;
        cyc("rst6", 8'd1, 1'b0);
        cyc("rst6", 8'd2, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst.out", {24'd0, out}, 32'd0);
        chk("async_rst.tc", {31'd0, tc}, 32'd0);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        min_val = 8'd10; max_val = 8'd20; load_val = 8'd19; load = 1'b1;
        cyc("cl.load", 8'd19, 1'b0);
        load = 1'b0;
        cyc("cl.step", 8'd20, 1'b1);
        clr = 1'b1; load = 1'b1; load_val = 8'd50;
        cyc("clr_load", 8'd10, 1'b0);
        chk("clr_load.at_min", {31'd0, at_min}, 32'd1);
        clr = 1'b0; load = 1'b0;
        cyc("after", 8'd11, 1'b0);

        chk("sb_empty", sb_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
